// File: rtl/rx_bit_packer_pkg.sv
// Shared types for the RX dibit-to-byte packer: FIFO entry layout and packer FSM states.
package rx_bit_packer_pkg;

  localparam int DIBITS_PER_BYTE = 4;

  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } fifo_entry_t;

  typedef enum logic {
    WAIT_START,
    PACK
  } state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; dout is a register that always holds the head entry.
module rx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_addr_next;
  logic             do_push;
  logic             do_pop;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count        = wr_ptr - rd_ptr;
  assign rd_addr_next = rd_ptr[AW-1:0] + AW'(1);
  assign do_pop       = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_push      = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      // Keep the head register current: refill from memory, or bypass din when storage runs dry.
      if (empty) begin
        if (do_push) dout <= din;
      end else if (do_pop) begin
        if (count != (AW+1)'(1)) dout <= mem[rd_addr_next];
        else if (do_push)        dout <= din;
      end
    end
  end

endmodule

// File: rtl/rx_bit_packer.sv
// Packs the demodulated RX dibit stream MSB-first into bytes, tags symbol starts and buffers them.
module rx_bit_packer
  import rx_bit_packer_pkg::*;
#(
  parameter int raw_symbol_length_g = 64,
  parameter int fifo_depth_g        = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  rx_rcv_data,
  input  logic        rx_rcv_data_valid,
  input  logic        rx_rcv_data_start,
  output logic [7:0]  byte_data,
  output logic        byte_sof,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        overflow,
  output logic        sync_err,
  output logic [15:0] symbol_cnt
);

  localparam int BYTES_PER_SYM = raw_symbol_length_g / 8;
  localparam int BIDX_W        = $clog2(BYTES_PER_SYM) + 1;

  if ((raw_symbol_length_g % 8) != 0 || raw_symbol_length_g <= 0) begin : g_len_chk
    $error("raw_symbol_length_g must be a positive multiple of 8");
  end
  if (fifo_depth_g < 4 || (fifo_depth_g & (fifo_depth_g - 1)) != 0) begin : g_depth_chk
    $error("fifo_depth_g must be a power of two and at least 4");
  end

  state_t              state, state_n;
  logic [7:0]          shift, shift_n, packed_byte;
  logic [1:0]          dibit_cnt, dibit_cnt_n;
  logic [BIDX_W-1:0]   byte_idx, byte_idx_n;
  logic                last_dibit, byte_done, sym_done, fresh, sync_hit;
  logic                vld_p1;
  fifo_entry_t         entry_p1, head;
  logic                fifo_empty, fifo_full, pop;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= WAIT_START;
    else         state <= state_n;
  end

  always_comb begin
    packed_byte = shift;
    case (dibit_cnt)
      2'd0:    packed_byte[7:6] = rx_rcv_data;
      2'd1:    packed_byte[5:4] = rx_rcv_data;
      2'd2:    packed_byte[3:2] = rx_rcv_data;
      default: packed_byte[1:0] = rx_rcv_data;
    endcase
    last_dibit  = (dibit_cnt == 2'(DIBITS_PER_BYTE - 1)) &&
                  (byte_idx == BIDX_W'(BYTES_PER_SYM - 1));
    state_n     = state;
    shift_n     = shift;
    dibit_cnt_n = dibit_cnt;
    byte_idx_n  = byte_idx;
    byte_done   = 1'b0;
    sym_done    = 1'b0;
    fresh       = 1'b0;
    sync_hit    = 1'b0;
    if (rx_rcv_data_valid) begin
      case (state)
        WAIT_START: fresh = rx_rcv_data_start;
        PACK: begin
          if (rx_rcv_data_start && !last_dibit) begin
            sync_hit = 1'b1;
            fresh    = 1'b1;
          end else begin
            shift_n     = packed_byte;
            dibit_cnt_n = dibit_cnt + 2'd1;
            if (dibit_cnt == 2'(DIBITS_PER_BYTE - 1)) begin
              byte_done   = 1'b1;
              dibit_cnt_n = 2'd0;
              byte_idx_n  = byte_idx + BIDX_W'(1);
            end
            if (last_dibit) begin
              sym_done = 1'b1;
              state_n  = WAIT_START;
              fresh    = rx_rcv_data_start;
            end
          end
        end
        default: state_n = WAIT_START;
      endcase
    end
    // A start dibit opens a new symbol: it lands in the top pair and the counters restart.
    if (fresh) begin
      shift_n     = {rx_rcv_data, 6'b0};
      dibit_cnt_n = 2'd1;
      byte_idx_n  = '0;
      state_n     = PACK;
    end
  end

  assign pop = byte_valid & byte_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dibit_cnt  <= '0;
      byte_idx   <= '0;
      vld_p1     <= 1'b0;
      symbol_cnt <= '0;
      sync_err   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dibit_cnt <= dibit_cnt_n;
      byte_idx  <= byte_idx_n;
      vld_p1    <= byte_done;
      if (sym_done) symbol_cnt <= symbol_cnt + 16'd1;
      if (sync_hit) sync_err <= 1'b1;
      if (vld_p1 && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Stage p1: completed byte registered before entering the FIFO.
  always_ff @(posedge sys_clk) begin
    shift         <= shift_n;
    entry_p1.sof  <= (byte_idx == '0);
    entry_p1.data <= packed_byte;
  end

  rx_byte_fifo #(
    .DEPTH (fifo_depth_g),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (vld_p1),
    .pop   (pop),
    .din   (entry_p1),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign byte_valid = ~fifo_empty;
  assign byte_data  = head.data;
  assign byte_sof   = head.sof;

endmodule

// File: tb/tb_rx_bit_packer.sv
// Directed bench for rx_bit_packer with a byte scoreboard checked at every output handshake.
module tb_rx_bit_packer;

  logic        sys_clk;
  logic        sys_rst;
  logic [1:0]  rx_rcv_data;
  logic        rx_rcv_data_valid;
  logic        rx_rcv_data_start;
  logic [7:0]  byte_data;
  logic        byte_sof;
  logic        byte_valid;
  logic        byte_ready;
  logic        overflow;
  logic        sync_err;
  logic [15:0] symbol_cnt;

  int          errors;
  int          checks;
  logic [8:0]  exp_q[$];
  logic [8:0]  exp_head;

  rx_bit_packer #(
    .raw_symbol_length_g (64),
    .fifo_depth_g        (16)
  ) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .rx_rcv_data       (rx_rcv_data),
    .rx_rcv_data_valid (rx_rcv_data_valid),
    .rx_rcv_data_start (rx_rcv_data_start),
    .byte_data         (byte_data),
    .byte_sof          (byte_sof),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .overflow          (overflow),
    .sync_err          (sync_err),
    .symbol_cnt        (symbol_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Scoreboard: every accepted output byte is matched against the oldest expected entry.
  always @(negedge sys_clk) begin
    if (!sys_rst && byte_valid && byte_ready) begin
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_byte observed=%h required=none", {byte_sof, byte_data});
      end
      if (exp_q.size() != 0) begin
        exp_head = exp_q.pop_front();
        checks++;
        assert ({byte_sof, byte_data} === exp_head)
        else begin
          errors++;
          $error("FAIL byte_out observed=%h required=%h", {byte_sof, byte_data}, exp_head);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_dibit(input logic [1:0] d, input logic s);
    rx_rcv_data       = d;
    rx_rcv_data_valid = 1'b1;
    rx_rcv_data_start = s;
    @(posedge sys_clk);
    #1;
    rx_rcv_data_valid = 1'b0;
    rx_rcv_data_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first, input logic keep, input int gap);
    if (keep) exp_q.push_back({first, b});
    for (int k = 0; k < 4; k++) begin
      send_dibit(b[7-2*k -: 2], first && (k == 0));
      idle(gap);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || byte_valid) && n < max_cyc) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_valid_low"}, 32'(byte_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    errors            = 0;
    checks            = 0;
    sys_rst           = 1'b1;
    rx_rcv_data       = 2'd0;
    rx_rcv_data_valid = 1'b0;
    rx_rcv_data_start = 1'b0;
    byte_ready        = 1'b0;
    idle(2);
    sys_rst = 1'b0;

    // Reset state
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_data", 32'(byte_data), 32'd0);
    chk("rst_sof", 32'(byte_sof), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_symbol_cnt", 32'(symbol_cnt), 32'd0);

    // Basic packing: dibits 3,0,1,2 repeating, one valid every 25 clocks
    byte_ready = 1'b1;
    for (int j = 0; j < 8; j++) send_byte(8'hC6, j == 0, 1'b1, 24);
    drain("basic", 200);
    chk("basic_symbol_cnt", 32'(symbol_cnt), 32'd1);
    chk("basic_overflow", 32'(overflow), 32'd0);
    chk("basic_sync_err", 32'(sync_err), 32'd0);

    // Back-to-back symbols with first-byte latency check
    do_reset();
    byte_ready = 1'b1;
    b = 8'h20;
    exp_q.push_back({1'b1, b});
    for (int k = 0; k < 4; k++) send_dibit(b[7-2*k -: 2], k == 0);
    chk("lat_edge_n", 32'(byte_valid), 32'd0);
    b = 8'h21;
    exp_q.push_back({1'b0, b});
    send_dibit(b[7:6], 1'b0);
    chk("lat_edge_n1", 32'(byte_valid), 32'd1);
    for (int k = 1; k < 4; k++) send_dibit(b[7-2*k -: 2], 1'b0);
    for (int j = 2; j < 24; j++) send_byte(8'h20 + 8'(j), (j % 8) == 0, 1'b1, 0);
    drain("b2b", 200);
    chk("b2b_symbol_cnt", 32'(symbol_cnt), 32'd3);
    chk("b2b_overflow", 32'(overflow), 32'd0);

    // Backpressure: fill to 16, push+pop while full, then overflow
    do_reset();
    byte_ready = 1'b0;
    for (int j = 0; j < 16; j++) send_byte(8'h40 + 8'(j), (j % 8) == 0, 1'b1, 0);
    idle(2);
    chk("fill_valid", 32'(byte_valid), 32'd1);
    chk("fill_overflow", 32'(overflow), 32'd0);
    chk("fill_symbol_cnt", 32'(symbol_cnt), 32'd2);
    send_byte(8'h50, 1'b1, 1'b1, 0);
    byte_ready = 1'b1;
    idle(1);
    byte_ready = 1'b0;
    idle(2);
    chk("full_pushpop_overflow", 32'(overflow), 32'd0);
    for (int j = 1; j < 8; j++) send_byte(8'h50 + 8'(j), 1'b0, 1'b0, 0);
    idle(2);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk("ovf_symbol_cnt", 32'(symbol_cnt), 32'd3);
    chk("ovf_queue_depth", 32'(exp_q.size()), 32'd16);
    byte_ready = 1'b1;
    drain("ovf", 100);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Mid-symbol start: 2 bytes, 1 stray dibit, then a fresh symbol
    do_reset();
    chk("rst2_overflow", 32'(overflow), 32'd0);
    byte_ready = 1'b1;
    send_byte(8'hA5, 1'b1, 1'b1, 0);
    send_byte(8'h3C, 1'b0, 1'b1, 0);
    send_dibit(2'b11, 1'b0);
    send_byte(8'h90, 1'b1, 1'b1, 0);
    chk("mid_sync_err", 32'(sync_err), 32'd1);
    chk("mid_symbol_cnt", 32'(symbol_cnt), 32'd0);
    for (int j = 1; j < 8; j++) send_byte(8'h90 + 8'(j), 1'b0, 1'b1, 0);
    drain("mid", 100);
    chk("mid_symbol_cnt_after", 32'(symbol_cnt), 32'd1);
    chk("mid_sync_err_sticky", 32'(sync_err), 32'd1);

    // Reset mid-symbol, then dibits without start must be ignored
    do_reset();
    byte_ready = 1'b0;
    send_dibit(2'd1, 1'b1);
    send_dibit(2'd2, 1'b0);
    for (int j = 0; j < 5; j++) send_byte(8'h11 + 8'(j), j == 0, 1'b1, 0);
    send_dibit(2'd3, 1'b0);
    idle(2);
    chk("pre_rst_sync_err", 32'(sync_err), 32'd1);
    chk("pre_rst_valid", 32'(byte_valid), 32'd1);
    do_reset();
    chk("post_rst_valid", 32'(byte_valid), 32'd0);
    chk("post_rst_sync_err", 32'(sync_err), 32'd0);
    chk("post_rst_overflow", 32'(overflow), 32'd0);
    chk("post_rst_symbol_cnt", 32'(symbol_cnt), 32'd0);
    byte_ready = 1'b1;
    for (int j = 0; j < 3; j++) send_byte(8'hE7, 1'b0, 1'b0, 0);
    idle(5);
    chk("nostart_valid", 32'(byte_valid), 32'd0);
    for (int j = 0; j < 8; j++) send_byte(8'h70 + 8'(j), j == 0, 1'b1, 0);
    drain("restart", 100);
    chk("restart_symbol_cnt", 32'(symbol_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_bit_packer.md
Name: rx_bit_packer

Overview:
- Downstream of the OFDM RX top level; consumes its demodulated dibit stream (rx_rcv_data / rx_rcv_data_valid) plus a symbol-start marker.
- Packs dibits MSB-first into bytes, tags the first byte of every OFDM symbol, and buffers bytes in a small FIFO.
- Presents a valid/ready byte stream to the downstream MAC/host interface.
- Reports overflow and symbol-alignment errors as sticky flags.

Parameters:
- raw_symbol_length_g, 64, bits per OFDM symbol; must be a multiple of 8 (elaboration assertion).
- fifo_depth_g, 16, FIFO depth in bytes; power of two, at least 4.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- rx_rcv_data  in  2  demodulated dibit; bit 1 is the earlier bit.
- rx_rcv_data_valid  in  1  one-cycle qualifier for rx_rcv_data.
- rx_rcv_data_start  in  1  marks the first dibit of a symbol; only sampled when valid=1.
- byte_data  out  8  packed byte, FIFO head.
- byte_sof  out  1  byte_data is byte 0 of a symbol.
- byte_valid  out  1  FIFO not empty.
- byte_ready  in  1  consumer accepts the head byte when valid and ready are both 1.
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full.
- sync_err  out  1  sticky: a start arrived mid-symbol.
- symbol_cnt  out  16  count of completed symbols; wraps 0xFFFF -> 0.

Behaviour:
- Reset values (sys_rst=1 at a clock edge): all outputs 0, FIFO empty, FSM in WAIT_START, dibit and byte counters 0. Reset mid-operation discards any partial byte and all FIFO contents.
- FSM WAIT_START: ignores valid dibits without start. valid & start -> load the dibit into shift bits 7:6, dibit_cnt=1, byte_idx=0, go to PACK.
- FSM PACK: each valid dibit shifts into the next lower pair (7:6, 5:4, 3:2, 1:0).
  - When the 4th dibit lands, push {sof=(byte_idx==0), byte} into the FIFO, clear dibit_cnt, increment byte_idx.
  - After raw_symbol_length_g/2 dibits: symbol_cnt++, go to WAIT_START.
  - If the last dibit also carries start, symbol_cnt++ and start a new symbol in the same cycle (stay in PACK, counters restart at the new dibit).
- valid & start while in PACK, not at a symbol boundary: set sync_err, drop the partial byte, realign to the new symbol (treat as a fresh start). Bytes already completed remain in the FIFO. symbol_cnt is not incremented.
- Latency: byte completed at edge n; byte_valid=1 and byte_data valid after edge n+1 if the FIFO was empty (first-word fall-through).
- FIFO:
  - Pop when byte_valid & byte_ready.
  - Push when full and no pop in the same cycle: byte dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, occupancy unchanged.
  - Push and pop in the same cycle when empty: push only (the output is not yet valid).
- Input rate is at most one dibit per clock; back-to-back valids are legal.
- Sticky flags clear only on sys_rst.

Decomposition:
- Package rx_bit_packer_pkg:
  - DIBITS_PER_BYTE = 4.
  - fifo_entry_t, a packed struct {sof, data[7:0]}.
  - FSM enum {WAIT_START, PACK}.
- Sub-module rx_byte_fifo, a generic synchronous FWFT FIFO parameterised by depth:
  - ports: push, pop, din, dout, empty, full.
  - registered read data; pointer width is log2(depth) + 1.

Test Plan:
- Basic packing: start plus 32 dibits 3,0,1,2 repeating, valid every 25 clocks, byte_ready=1 -> 8 bytes 0xC6, first with sof=1, rest sof=0; symbol_cnt=1; no flags.
- Back-to-back input: 3 symbols, valid every clock, start on each first dibit -> 24 bytes in order; sof on bytes 0, 8 and 16; symbol_cnt=3; latency 1 clock from the 4th dibit to byte_valid.
- Backpressure and overflow: byte_ready=0, fifo_depth_g=16, 3 symbols (24 bytes) -> 16 bytes held, overflow=1. Release ready -> exactly those 16 drain in order, then byte_valid=0.
- Full with simultaneous push/pop: FIFO full and byte_ready=1 in the cycle a byte completes -> no overflow, occupancy stays 16.
- Mid-symbol start: start on dibit 10 of a symbol -> sync_err=1; the 2 complete bytes are kept; the partial byte is dropped; the next byte carries sof=1; symbol_cnt not incremented.
- Reset mid-symbol: sys_rst for 1 cycle after 5 bytes with ready=0 -> byte_valid=0, flags=0, symbol_cnt=0. Dibits without start are then ignored until the next start.
